// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad coefficient writer: frame header magic,
// per-section coefficient indices and the writer state encoding.
// The CHK state only exists when COEFF_CHECKSUM_EN is defined.
package biquad_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hB2;
  localparam int COEFFS_PER_SECTION = 5;

  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'(COEFFS_PER_SECTION - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
`ifdef COEFF_CHECKSUM_EN
    ST_CHK    = 3'd2,
`endif
    ST_DRAIN  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

endpackage

// File: rtl/biquad_coeff_writer.sv
// Runtime coefficient writer for the biquad cascade. Parses a framed
// coefficient stream (header, 5*N coefficients, optional XOR checksum),
// emits one registered write strobe per coefficient into the section shadow
// banks and pulses commit once a complete, valid frame has been received.
// Optional feature macro: COEFF_CHECKSUM_EN (trailing XOR checksum word).
module biquad_coeff_writer
  import biquad_pkg::*;
#(
  parameter int SECTIONS = 4,
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BITWIDTH-1:0] s_data,
  input  logic                s_last,
  output logic                cw_en,
  output logic [7:0]          cw_sec,
  output logic [2:0]          cw_idx,
  output logic [BITWIDTH-1:0] cw_data,
  output logic                commit,
  output logic                err,
  output logic                busy
);

  localparam logic [7:0] MAX_SECTIONS = 8'(SECTIONS);

  state_t r_state;
  state_t w_nextState;

  logic                r_ready;
  logic                r_cwEn;
  logic [7:0]          r_cwSec;
  logic [2:0]          r_cwIdx;
  logic [BITWIDTH-1:0] r_cwData;
  logic                r_commit;
  logic                r_err;
  logic                r_busy;

  logic [7:0]          r_secCnt;
  logic [2:0]          r_idxCnt;
  logic [7:0]          r_numSec;
`ifdef COEFF_CHECKSUM_EN
  logic [BITWIDTH-1:0] r_xor;
`endif

  logic       w_accept;
  logic [7:0] w_hdrMagic;
  logic [7:0] w_hdrCount;
  logic       w_hdrOk;
  logic       w_finalCoeff;
  logic       w_frameErr;
  logic       w_write;
  logic       w_hdrStart;
  logic       w_nextReady;
  logic       w_nextBusy;
  logic       w_nextCommit;

  assign w_accept     = s_valid & r_ready;
  assign w_hdrMagic   = s_data[BITWIDTH-1 -: 8];
  assign w_hdrCount   = s_data[7:0];
  assign w_hdrOk      = (w_hdrMagic == HDR_MAGIC) && (w_hdrCount != 8'd0) &&
                        (w_hdrCount <= MAX_SECTIONS);
  assign w_finalCoeff = (r_idxCnt == IDX_A2) && (r_secCnt == r_numSec - 8'd1);

  // State register: synchronous reset returns to IDLE, aborting any frame.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic: frame parsing and rejection decisions per accepted word.
  always_comb begin
    w_nextState = r_state;
    w_frameErr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_hdrOk) begin
            w_frameErr  = 1'b1;
            w_nextState = s_last ? ST_IDLE : ST_DRAIN;
          end else if (s_last) begin
            w_frameErr  = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_nextState = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (w_finalCoeff) begin
`ifdef COEFF_CHECKSUM_EN
            if (s_last) begin
              w_frameErr  = 1'b1;
              w_nextState = ST_IDLE;
            end else begin
              w_nextState = ST_CHK;
            end
`else
            if (s_last) begin
              w_nextState = ST_COMMIT;
            end else begin
              w_frameErr  = 1'b1;
              w_nextState = ST_DRAIN;
            end
`endif
          end else if (s_last) begin
            w_frameErr  = 1'b1;
            w_nextState = ST_IDLE;
          end
        end
      end
`ifdef COEFF_CHECKSUM_EN
      ST_CHK: begin
        if (w_accept) begin
          if (s_last && (s_data == r_xor)) begin
            w_nextState = ST_COMMIT;
          end else begin
            w_frameErr  = 1'b1;
            w_nextState = s_last ? ST_IDLE : ST_DRAIN;
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (w_accept && s_last) w_nextState = ST_IDLE;
      end
      ST_COMMIT: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered strobes and status flags.
  always_comb begin
    w_write      = (r_state == ST_LOAD) && w_accept;
    w_hdrStart   = (r_state == ST_IDLE) && w_accept && (w_nextState == ST_LOAD);
    w_nextCommit = (w_nextState == ST_COMMIT);
    w_nextReady  = (w_nextState != ST_COMMIT);
    w_nextBusy   = (w_nextState != ST_IDLE) && (w_nextState != ST_COMMIT);
  end

  // Registered outputs plus section/index counters and checksum accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_cwEn   <= 1'b0;
      r_cwSec  <= 8'd0;
      r_cwIdx  <= 3'd0;
      r_cwData <= '0;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_secCnt <= 8'd0;
      r_idxCnt <= 3'd0;
      r_numSec <= 8'd0;
`ifdef COEFF_CHECKSUM_EN
      r_xor    <= '0;
`endif
    end else begin
      r_ready  <= w_nextReady;
      r_commit <= w_nextCommit;
      r_err    <= w_frameErr;
      r_busy   <= w_nextBusy;
      r_cwEn   <= w_write;
      if (w_hdrStart) begin
        r_numSec <= w_hdrCount;
        r_secCnt <= 8'd0;
        r_idxCnt <= IDX_B0;
`ifdef COEFF_CHECKSUM_EN
        r_xor    <= '0;
`endif
      end
      if (w_write) begin
        r_cwSec  <= r_secCnt;
        r_cwIdx  <= r_idxCnt;
        r_cwData <= s_data;
`ifdef COEFF_CHECKSUM_EN
        r_xor    <= r_xor ^ s_data;
`endif
        if (r_idxCnt == IDX_A2) begin
          r_idxCnt <= IDX_B0;
          r_secCnt <= r_secCnt + 8'd1;
        end else begin
          r_idxCnt <= r_idxCnt + 3'd1;
        end
      end
    end
  end

  assign s_ready = r_ready;
  assign cw_en   = r_cwEn;
  assign cw_sec  = r_cwSec;
  assign cw_idx  = r_cwIdx;
  assign cw_data = r_cwData;
  assign commit  = r_commit;
  assign err     = r_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_biquad_coeff_writer.sv
// Self-checking bench for biquad_coeff_writer. Frames are built as word/last
// queues, driven through the handshake, and the observed writes, commits and
// errors are compared against a frame-level reference model.
// Honours COEFF_CHECKSUM_EN the same way as the design.
module tb_biquad_coeff_writer;

  localparam int SECTIONS = 4;
  localparam int BW       = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          s_last;
  logic          cw_en;
  logic [7:0]    cw_sec;
  logic [2:0]    cw_idx;
  logic [BW-1:0] cw_data;
  logic          commit;
  logic          err;
  logic          busy;

  biquad_coeff_writer #(.SECTIONS(SECTIONS), .BITWIDTH(BW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .cw_en   (cw_en),
    .cw_sec  (cw_sec),
    .cw_idx  (cw_idx),
    .cw_data (cw_data),
    .commit  (commit),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;
  int cyc = 0;

  // Observed traffic, sampled on the falling edge.
  logic [7:0]    obsSec[$];
  logic [2:0]    obsIdx[$];
  logic [BW-1:0] obsData[$];
  int commitCnt = 0, errCnt = 0;
  int commitNeg = -1, errNeg = -1, lastWriteNeg = -1;

  // Frame under test and the model's expectation for it.
  logic [BW-1:0] fw[$];
  bit            fl[$];
  int            accNeg[$];
  logic [7:0]    expSec[$];
  logic [2:0]    expIdx[$];
  logic [BW-1:0] expData[$];
  int expCommit, expErr;
  int cBase, eBase;

  // Cycle counter advances on the rising edge so falling-edge readers agree.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor collects write strobes and pulse events away from the active edge.
  always @(negedge clk) begin
    if (cw_en === 1'b1) begin
      obsSec.push_back(cw_sec);
      obsIdx.push_back(cw_idx);
      obsData.push_back(cw_data);
      lastWriteNeg = cyc;
    end
    if (commit === 1'b1) begin
      commitCnt++;
      commitNeg = cyc;
    end
    if (err === 1'b1) begin
      errCnt++;
      errNeg = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of the frame in fw/fl, derived from the framing rules.
  task automatic refModel();
    logic [BW-1:0] hdr;
    logic [BW-1:0] x;
    int n, total;
    expSec.delete(); expIdx.delete(); expData.delete();
    expCommit = 0;
    expErr = 0;
    hdr = fw[0];
    n = int'(hdr[7:0]);
    if (hdr[BW-1 -: 8] != 8'hB2 || n < 1 || n > SECTIONS) begin
      expErr = 1;
      return;
    end
    if (fl[0]) begin
      expErr = 1;
      return;
    end
    total = 5 * n;
    x = '0;
    for (int k = 1; k <= total; k++) begin
      if (k >= fw.size()) return;
      expSec.push_back(8'((k - 1) / 5));
      expIdx.push_back(3'((k - 1) % 5));
      expData.push_back(fw[k]);
      x = x ^ fw[k];
      if (k < total && fl[k]) begin
        expErr = 1;
        return;
      end
    end
`ifdef COEFF_CHECKSUM_EN
    if (fl[total]) begin
      expErr = 1;
      return;
    end
    if (total + 1 < fw.size() && fw[total+1] == x && fl[total+1]) expCommit = 1;
    else expErr = 1;
`else
    if (fl[total]) expCommit = 1;
    else expErr = 1;
`endif
  endtask

  task automatic startFrame();
    obsSec.delete(); obsIdx.delete(); obsData.delete();
    fw.delete(); fl.delete(); accNeg.delete();
    cBase = commitCnt;
    eBase = errCnt;
  endtask

  task automatic pushWord(input logic [BW-1:0] w, input bit l);
    fw.push_back(w);
    fl.push_back(l);
  endtask

  function automatic logic [BW-1:0] makeHeader(input logic [7:0] magic, input int n);
    logic [15:0] mid;
    mid = 16'($urandom);
    return {magic, mid, 8'(n)};
  endfunction

  // Well-formed frame; coefficients sequential from 1 or random.
  task automatic buildGood(input int n, input bit seq);
    logic [BW-1:0] x;
    logic [BW-1:0] c;
    x = '0;
    pushWord(makeHeader(8'hB2, n), 1'b0);
    for (int k = 1; k <= 5 * n; k++) begin
      c = seq ? BW'(k) : BW'($urandom);
      x = x ^ c;
`ifdef COEFF_CHECKSUM_EN
      pushWord(c, 1'b0);
`else
      pushWord(c, k == 5 * n);
`endif
    end
`ifdef COEFF_CHECKSUM_EN
    pushWord(x, 1'b1);
`endif
  endtask

  // Drives fw/fl; gapMode 0 back-to-back, 1 one idle cycle per word, 2 random idles.
  task automatic applyStimulus(input int gapMode);
    int t;
    for (int i = 0; i < fw.size(); i++) begin
      if (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1)) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = fw[i];
      s_last  = fl[i];
      t = 0;
      while (s_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (s_ready !== 1'b1) begin
        checkOutput("ready_timeout", {63'd0, s_ready}, 64'd1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      accNeg.push_back(cyc);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // Compares everything the frame produced with the model.
  task automatic checkFrame(input string tag);
    int m;
    repeat (3) @(negedge clk);
    refModel();
    checkOutput({tag, "_nwr"}, 64'(obsSec.size()), 64'(expSec.size()));
    m = (obsSec.size() < expSec.size()) ? obsSec.size() : expSec.size();
    for (int i = 0; i < m; i++)
      checkOutput({tag, "_wr"}, {21'd0, obsSec[i], obsIdx[i], obsData[i]},
                  {21'd0, expSec[i], expIdx[i], expData[i]});
    checkOutput({tag, "_commit"}, 64'(commitCnt - cBase), 64'(expCommit));
    checkOutput({tag, "_err"}, 64'(errCnt - eBase), 64'(expErr));
    if (expCommit == 1 && accNeg.size() > 0) begin
      checkOutput({tag, "_ctime"}, 64'(commitNeg), 64'(accNeg[accNeg.size()-1]));
`ifndef COEFF_CHECKSUM_EN
      checkOutput({tag, "_wtime"}, 64'(lastWriteNeg), 64'(commitNeg));
`endif
    end
    checkOutput({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_idle_ready"}, {63'd0, s_ready}, 64'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, {63'd0, s_ready}, 64'd0);
    checkOutput({tag, "_outs"}, {20'd0, cw_en, cw_sec, cw_idx, commit, err, busy, cw_data},
                64'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {63'd0, s_ready}, 64'd1);

    // N=2 with coefficients 1..10.
    startFrame();
    buildGood(2, 1'b1);
    applyStimulus(0);
    checkFrame("seq2");

    // Bad magic header, junk drained through s_last, then a good frame.
    startFrame();
    pushWord(32'hA2000001, 1'b0);
    pushWord(BW'($urandom), 1'b0);
    pushWord(BW'($urandom), 1'b0);
    pushWord(BW'($urandom), 1'b1);
    applyStimulus(0);
    checkFrame("badmagic");
    checkOutput("badmagic_etime", 64'(errNeg), 64'(accNeg[0]));
    startFrame();
    buildGood(1, 1'b0);
    applyStimulus(0);
    checkFrame("after_drain");

    // N=1 with a broken tail: wrong checksum, or final coefficient missing s_last.
    startFrame();
    buildGood(1, 1'b0);
`ifdef COEFF_CHECKSUM_EN
    fw[fw.size()-1] = fw[fw.size()-1] + 1;
`else
    fl[fl.size()-1] = 1'b0;
    pushWord(BW'($urandom), 1'b1);
`endif
    applyStimulus(0);
    checkFrame("badtail");

    // Section count one past the limit, single-word frame.
    startFrame();
    pushWord(makeHeader(8'hB2, SECTIONS + 1), 1'b1);
    applyStimulus(0);
    checkFrame("toomany");

    // Zero sections is also rejected.
    startFrame();
    pushWord(makeHeader(8'hB2, 0), 1'b1);
    applyStimulus(0);
    checkFrame("zero");

    // Valid header that ends the frame.
    startFrame();
    pushWord(makeHeader(8'hB2, 1), 1'b1);
    applyStimulus(0);
    checkFrame("hdrlast");

    // Early s_last in the middle of coefficient loading.
    startFrame();
    buildGood(2, 1'b0);
    fl[4] = 1'b1;
    while (fw.size() > 5) begin
      void'(fw.pop_back());
      void'(fl.pop_back());
    end
    applyStimulus(0);
    checkFrame("early");

    // N=3 with s_valid toggling every other cycle.
    startFrame();
    buildGood(3, 1'b0);
    applyStimulus(1);
    checkFrame("toggle3");

    // Largest section count.
    startFrame();
    buildGood(SECTIONS, 1'b0);
    applyStimulus(0);
    checkFrame("maxsec");

    // Randomized good frames with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      startFrame();
      buildGood(int'($urandom_range(1, SECTIONS)), 1'b0);
      applyStimulus(2);
      checkFrame("rand");
    end

    // Reset after the third coefficient aborts quietly.
    startFrame();
    pushWord(makeHeader(8'hB2, 2), 1'b0);
    for (int k = 0; k < 3; k++) pushWord(BW'($urandom), 1'b0);
    applyStimulus(0);
    checkOutput("midframe_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midrst");
    checkOutput("midrst_commit", 64'(commitCnt - cBase), 64'd0);
    checkOutput("midrst_err", 64'(errCnt - eBase), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", {63'd0, s_ready}, 64'd1);
    startFrame();
    buildGood(2, 1'b0);
    applyStimulus(0);
    checkFrame("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/biquad_coeff_writer.md
# biquad_coeff_writer

Runtime coefficient writer for the cascaded second-order IIR sections. It accepts a framed coefficient stream over a valid/ready handshake, validates it, and emits per-coefficient write strobes into each section's shadow coefficient bank. A single commit pulse then swaps every section to the new set at once, replacing the static file preload with live reprogramming. It sits between the host/config interface and the biquad cascade.

## Interface
- SECTIONS, 4, number of biquad sections addressable (1..255)
- BITWIDTH, 32, coefficient/stream word width; must match section bitwidth; ≥16
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- s_valid  in  1  stream word valid
- s_ready  out  1  writer can accept word
- s_data  in  BITWIDTH  stream word (header, coefficient, or checksum)
- s_last  in  1  marks final word of frame
- cw_en  out  1  coefficient write strobe to shadow bank
- cw_sec  out  8  target section index
- cw_idx  out  3  coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
- cw_data  out  BITWIDTH  coefficient value, two's complement, same fixed-point scale as section coefficients
- commit  out  1  one-cycle pulse: all sections swap shadow bank to active
- err  out  1  one-cycle pulse: frame rejected
- busy  out  1  high from header accept until frame end (commit, err, or drain complete)

## Operation
- Frame: header word, then 5×N coefficient words ordered section 0..N-1, each b0,b1,b2,a1,a2; optional checksum word (see Configuration).
- Header: s_data[BITWIDTH-1 -: 8] == 8'hB2 (magic); s_data[7:0] = N; valid iff 1 ≤ N ≤ SECTIONS.
- States: IDLE (await header), LOAD (coefficients), CHK (checksum word, macro only), DRAIN (discard to s_last), COMMIT (one cycle).
- IDLE: accepted word with bad magic or bad N -> err; if s_last on that word -> IDLE, else DRAIN. Valid header with s_last set -> err, IDLE. Otherwise LOAD, counters cleared.
- LOAD: each accepted word drives cw_en with current cw_sec/cw_idx; cw_idx wraps 4->0 and increments cw_sec. s_last before final coefficient -> err, IDLE. Final coefficient: without checksum, must carry s_last -> COMMIT, else err, DRAIN; with checksum, must not carry s_last -> CHK, else err, IDLE.
- CHK: word must equal running XOR of all coefficient words and carry s_last -> COMMIT. Mismatch or missing s_last -> err; IDLE if s_last else DRAIN.
- DRAIN: accept and discard until s_last accepted -> IDLE; no cw_en.
- COMMIT: commit=1 for one cycle, s_ready=0, -> IDLE.
- Rejected frames never commit; shadow contents after partial writes are don't-care (active bank unchanged).

## Timing
- Reset values: s_ready=0, cw_en=0, cw_sec=0, cw_idx=0, cw_data=0, commit=0, err=0, busy=0; state IDLE, XOR accumulator 0. s_ready rises first cycle after rst deasserts.
- Word accepted on cycle where s_valid & s_ready. s_ready=1 in IDLE, LOAD, CHK, DRAIN; 0 in COMMIT and during rst.
- cw_en/cw_sec/cw_idx/cw_data registered: valid the cycle after acceptance, for exactly one cycle.
- commit asserts the cycle after final word accepted (same cycle as last cw_en when no checksum); err asserts the cycle after the offending word.
- Sustained throughput: one word per cycle; frame with N sections and checksum occupies 5N+2 accept cycles plus one COMMIT cycle.
- rst mid-frame: abort immediately, no commit, no err, all outputs to reset values next cycle.

## Configuration
- COEFF_CHECKSUM_EN defined: CHK state present; frame carries trailing XOR checksum word; mismatch -> err.
- Not defined: no CHK state or accumulator; final coefficient word must carry s_last; frame is 5N+1 words.

## Structure
- Shared package biquad_pkg: magic constant 8'hB2, coefficient index constants (B0..A2), COEFFS_PER_SECTION=5, state enum.
- Single module; no sub-module needed. The shadow bank/commit consumer lives in the section, not here.

## Test plan
- N=2, 10 coefficients 1..10, correct checksum 0x0B -> ten cw_en pulses (sec0 idx0..4 = 1..5, sec1 = 6..10), commit one cycle after checksum, err never.
- Header 0xA2000001 -> err pulse, no cw_en; DRAIN consumes through s_last; next good frame commits.
- N=1, checksum off by one -> 5 cw_en pulses, err, no commit.
- N=SECTIONS+1 header with s_last -> err, IDLE, s_ready stays high.
- s_valid toggled every other cycle during N=3 frame -> 15 cw_en in order, commit, no drops.
- rst asserted after 3rd coefficient -> no commit/err, outputs zero next cycle, subsequent frame commits normally.
